fa32_adder: RTL and testbench
=============================

Name: fa32_adder

Overview:
- 32-bit binary adder with carry-in and carry-out, registered output; used as the datapath adder primitive.
- Built from per-bit full-adder cells grouped into carry-lookahead blocks.
- One-cycle latency with a valid qualifier.
- A purely behavioural model (a + b + cin) is the golden comparison for verification.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- GROUP, 4, bits per carry-lookahead group. WIDTH must be a multiple of GROUP; otherwise elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- out_valid  output  1  sum/cout valid
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of the full sum
- mismatch  output  1  self-check flag; present only with FA32_SELFCHECK_EN

Behaviour:
- Reset: rst_n low asynchronously clears out_valid, sum, cout (and mismatch) to 0. They stay 0 while rst_n is low.
- Reset release takes effect on the next rising clk edge.
- Arithmetic: {cout, sum} = a + b + cin, computed as an unsigned WIDTH+1-bit result. No signed overflow flag.
- Structure:
  - Per bit: p = a^b, g = a&b.
  - Group carry: c[i+1] = g[i] | p[i]&c[i], expanded within each GROUP as lookahead.
  - Group carries ripple between groups, starting from cin.
  - Sum bit = p ^ c.
- Latency: 1 cycle. If in_valid is high at edge N, then sum/cout reflect that cycle's a, b, cin after edge N, and out_valid = 1.
- in_valid low at an edge:
  - out_valid goes to 0.
  - sum/cout hold their previous values (no register update).
- No backpressure. A new operation is accepted every cycle.
- Wrap-around: a = b = 2^WIDTH−1 with cin = 1 gives sum = 2^WIDTH−1, cout = 1.
- Combinational path from inputs to register must contain no latches.
- X on inputs while in_valid is low must not propagate to the outputs.

Optional Feature:
- Macro: FA32_SELFCHECK_EN.
- Defined:
  - A behavioural adder computes a + b + cin in parallel with the structural adder.
  - Its result is registered under the same in_valid/reset rules.
  - mismatch is 1 for one cycle when the registered structural {cout, sum} differs from the behavioural result and out_valid = 1; otherwise mismatch is 0.
  - Reset value is 0.
- Undefined:
  - mismatch port and behavioural logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 mid-operation with out_valid = 1 → out_valid, sum, cout go to 0 immediately without a clock edge.
- Exhaustive low nibble: a, b each in 0x0..0xE, cin in {0, 1}, in_valid = 1 → after one edge sum = a + b + cin, cout = 0. Example: a = 0xE, b = 0xE, cin = 1 → sum = 0x0000001D, cout = 0.
- High range: a, b each in 0xFFFFFFF0..0xFFFFFFFE, cin in {0, 1} → cout = 1. Example: a = b = 0xFFFFFFFE, cin = 1 → sum = 0xFFFFFFFD.
- Full carry ripple: a = 0xFFFFFFFF, b = 0, cin = 1 → sum = 0, cout = 1. Then a = 0x7FFFFFFF, b = 1, cin = 0 → sum = 0x80000000, cout = 0.
- Valid gating: in_valid = 1 with a = 5, b = 3, cin = 0; next cycle in_valid = 0 with a = 0xFFFFFFFF → out_valid drops to 0, sum holds 0x00000008.
- With FA32_SELFCHECK_EN defined: random back-to-back operations for ≥10k cycles → mismatch never asserts. Behavioural {cout, sum} equals structural {cout, sum} on every valid cycle.

Source files
------------

// File: rtl/fa32_adder.sv
// fa32_adder: registered WIDTH-bit adder built from grouped carry-lookahead
// cells. Ports: clk, rst_n, in_valid, a, b, cin -> out_valid, sum, cout, and
// mismatch only when FA32_SELFCHECK_EN is defined.
module fa32_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef FA32_SELFCHECK_EN
  output logic             cout,
  output logic             mismatch
`else
  output logic             cout
`endif
);

  localparam int NG = WIDTH / GROUP;

  generate
    if (WIDTH % GROUP != 0) begin : g_bad_group
      $error("fa32_adder: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign p = a ^ b;
  assign g = a & b;

  // Inside a group every carry is a flat sum of products of the
  // group's g/p and its carry-in; only group carries ripple.
  always_comb begin : carry_net
    logic gc;
    logic cl;
    logic prod;
    c    = '0;
    c[0] = cin;
    gc   = cin;
    cl   = 1'b0;
    prod = 1'b0;
    for (int grp = 0; grp < NG; grp++) begin
      for (int j = 0; j < GROUP; j++) begin
        prod = gc;
        for (int m = 0; m <= j; m++) begin
          prod = prod & p[grp*GROUP+m];
        end
        cl = prod;
        for (int k = 0; k <= j; k++) begin
          prod = g[grp*GROUP+k];
          for (int m = k + 1; m <= j; m++) begin
            prod = prod & p[grp*GROUP+m];
          end
          cl = cl | prod;
        end
        c[grp*GROUP+j+1] = cl;
      end
      gc = c[(grp+1)*GROUP];
    end
  end

  assign sum_d  = p ^ c[WIDTH-1:0];
  assign cout_d = c[WIDTH];

  // Operands are only sampled when valid, so X on idle inputs never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_d;
        cout <= cout_d;
      end
    end
  end

`ifdef FA32_SELFCHECK_EN
  logic [WIDTH:0] ref_d;
  logic [WIDTH:0] ref_q;

  assign ref_d = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else if (in_valid) begin
      ref_q <= ref_d;
    end
  end

  assign mismatch = out_valid && ({cout, sum} != ref_q);
`endif

endmodule

// File: tb/tb_fa32_adder.sv
// tb_fa32_adder: directed table, exhaustive corner loops and random
// back-to-back traffic against an arithmetic model of fa32_adder.
module tb_fa32_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic [31:0] sum;
  logic        cout;
`ifdef FA32_SELFCHECK_EN
  logic        mismatch;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fa32_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .sum(sum),
`ifdef FA32_SELFCHECK_EN
    .cout(cout),
    .mismatch(mismatch)
`else
    .cout(cout)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [32:0] model(logic [31:0] x, logic [31:0] y,
                                        logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(logic v, logic [31:0] x, logic [31:0] y, logic ci);
    @(negedge clk);
    in_valid = v;
    a = x;
    b = y;
    cin = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_op(string name, logic [32:0] exp);
    chk({name, ".valid"}, {32'd0, out_valid}, 33'd1);
    chk({name, ".sum"}, {cout, sum}, exp);
  endtask

  logic [32:0] e;
  logic        ev;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", {32'd0, out_valid}, 33'd0);
    chk("reset.sum", {cout, sum}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{32'h0000000E, 32'h0000000E, 1'b1, 32'h0000001D, 1'b0});
    tbl.push_back('{32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 1'b1});
    tbl.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1});
    tbl.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0});
    tbl.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0});
    tbl.push_back('{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0});
    foreach (tbl[i]) begin
      apply(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
      chk_op($sformatf("tbl%0d", i), {tbl[i].co, tbl[i].s});
    end

    for (int x = 0; x <= 14; x++)
      for (int y = 0; y <= 14; y++)
        for (int ci = 0; ci <= 1; ci++) begin
          apply(1'b1, 32'(x), 32'(y), 1'(ci));
          e = model(32'(x), 32'(y), 1'(ci));
          chk_op("nibble", e);
          chk("nibble.cout", {32'd0, cout}, 33'd0);
        end

    for (int x = 0; x <= 14; x++)
      for (int y = 0; y <= 14; y++)
        for (int ci = 0; ci <= 1; ci++) begin
          apply(1'b1, 32'hFFFFFFF0 + 32'(x), 32'hFFFFFFF0 + 32'(y), 1'(ci));
          e = model(32'hFFFFFFF0 + 32'(x), 32'hFFFFFFF0 + 32'(y), 1'(ci));
          chk_op("high", e);
          chk("high.cout", {32'd0, cout}, 33'd1);
        end

    apply(1'b1, 32'd5, 32'd3, 1'b0);
    chk_op("gate.load", 33'd8);
    apply(1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
    chk("gate.valid", {32'd0, out_valid}, 33'd0);
    chk("gate.hold", {cout, sum}, 33'd8);
    apply(1'b0, 32'bx, 32'bx, 1'bx);
    chk("gate.xhold", {cout, sum}, 33'd8);

    apply(1'b1, 32'hFFFFFFFF, 32'h00000003, 1'b1);
    chk_op("rst.pre", 33'h1_00000003);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.async.valid", {32'd0, out_valid}, 33'd0);
    chk("rst.async.sum", {cout, sum}, 33'd0);
    @(posedge clk);
    #1;
    chk("rst.hold.valid", {32'd0, out_valid}, 33'd0);
    chk("rst.hold.sum", {cout, sum}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    ev = 1'b0;
    e = '0;
    for (int n = 0; n < 12000; n++) begin
      logic        v;
      logic [31:0] x;
      logic [31:0] y;
      logic        ci;
      v  = ($urandom_range(0, 3) != 0);
      x  = $urandom;
      y  = $urandom;
      ci = 1'($urandom_range(0, 1));
      if (n % 7 == 0) x = 32'hFFFFFFFF ^ y;
      apply(v, x, y, ci);
      ev = v;
      if (v) e = model(x, y, ci);
      chk("rand.valid", {32'd0, out_valid}, {32'd0, ev});
      chk("rand.sum", {cout, sum}, e);
`ifdef FA32_SELFCHECK_EN
      chk("rand.selfcheck", {32'd0, mismatch}, 33'd0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
